// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit: one shift-add or restoring shift-subtract step
// per cycle; signed operations run on magnitudes with a sign fixup on the way out.
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             ZF,
    output logic             OF,
    output logic             DZ
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;
    state_t r_state, w_state_next;

    logic [CW-1:0]      r_cnt;
    logic               r_div, r_dz_pend, r_of_pend, r_neg_q, r_neg_r;
    logic [WIDTH-1:0]   r_opnd, r_acc, r_sh;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic               r_zf, r_of, r_dz;

    logic               w_load, w_last, w_fin_entry;
    logic               w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag;
    logic [WIDTH:0]     w_sum, w_trial;
    logic [WIDTH-1:0]   w_acc_step, w_sh_step;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo, w_rem;

    assign w_load      = start && (r_state != S_CALC);
    assign w_last      = (r_cnt == CW'(WIDTH));
    assign w_fin_entry = (r_state == S_CALC) && (r_dz_pend || w_last);

    assign w_a_neg = op[0] & A[WIDTH-1];
    assign w_b_neg = op[0] & B[WIDTH-1];
    assign w_a_mag = w_a_neg ? -A : A;
    assign w_b_mag = w_b_neg ? -B : B;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_CALC;
            S_CALC:  if (r_dz_pend || w_last) w_state_next = S_FIN;
            S_FIN:   w_state_next = start ? S_CALC : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // r_acc holds the running high product / partial remainder, r_sh the
    // multiplier being consumed or the dividend being turned into the quotient.
    always_comb begin
        w_sum   = {1'b0, r_acc} + (r_sh[0] ? {1'b0, r_opnd} : '0);
        w_trial = {r_acc, r_sh[WIDTH-1]} - {1'b0, r_opnd};
        if (!r_div) begin
            w_acc_step = w_sum[WIDTH:1];
            w_sh_step  = {w_sum[0], r_sh[WIDTH-1:1]};
        end else if (!w_trial[WIDTH]) begin
            w_acc_step = w_trial[WIDTH-1:0];
            w_sh_step  = {r_sh[WIDTH-2:0], 1'b1};
        end else begin
            w_acc_step = {r_acc[WIDTH-2:0], r_sh[WIDTH-1]};
            w_sh_step  = {r_sh[WIDTH-2:0], 1'b0};
        end
    end

    assign w_prod = r_neg_q ? -{r_acc, r_sh} : {r_acc, r_sh};
    assign w_quo  = r_neg_q ? -r_sh : r_sh;
    assign w_rem  = r_neg_r ? -r_acc : r_acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_div     <= 1'b0;
            r_dz_pend <= 1'b0;
            r_of_pend <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_opnd    <= '0;
            r_acc     <= '0;
            r_sh      <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_zf      <= 1'b1;
            r_of      <= 1'b0;
            r_dz      <= 1'b0;
        end else begin
            if (w_load) begin
                r_cnt     <= '0;
                r_div     <= op[1];
                r_dz_pend <= op[1] && (B == '0);
                r_of_pend <= (op == 2'b11) && (A == MIN_NEG) && (B == '1);
                r_neg_q   <= w_a_neg ^ w_b_neg;
                r_neg_r   <= w_a_neg;
                r_opnd    <= op[1] ? w_b_mag : w_a_mag;
                r_sh      <= op[1] ? w_a_mag : w_b_mag;
                r_acc     <= (op[1] && (B == '0)) ? A : '0;
            end else if ((r_state == S_CALC) && !w_last && !r_dz_pend) begin
                r_acc <= w_acc_step;
                r_sh  <= w_sh_step;
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_fin_entry) begin
                if (r_dz_pend) begin
                    r_hi <= r_acc;
                    r_lo <= '1;
                    r_zf <= 1'b0;
                    r_of <= 1'b0;
                    r_dz <= 1'b1;
                end else if (r_div) begin
                    r_hi <= w_rem;
                    r_lo <= w_quo;
                    r_zf <= (w_quo == '0);
                    r_of <= r_of_pend;
                    r_dz <= 1'b0;
                end else begin
                    {r_hi, r_lo} <= w_prod;
                    r_zf <= (w_prod == '0);
                    r_of <= 1'b0;
                    r_dz <= 1'b0;
                end
            end
        end
    end

    assign busy = (r_state == S_CALC);
    assign done = (r_state == S_FIN);
    assign HI   = r_hi;
    assign LO   = r_lo;
    assign ZF   = r_zf;
    assign OF   = r_of;
    assign DZ   = r_dz;
endmodule
